// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-order feature-map stream.
// A half-row line buffer holds the top-row pair maxima until the matching bottom row arrives.
module relu_maxpool #(
    parameter int FMAP_SIZE = 28,
    parameter int SUM_BW    = 16,
    parameter int CNT_BW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SUM_BW-1:0] i_y,
    input  logic                     i_valid,
    output logic        [SUM_BW-1:0] o_y,
    output logic                     o_valid,
    output logic                     o_frame_done
);

    localparam int POOL = FMAP_SIZE / 2;
    localparam int LAST = 2 * POOL - 1;
    localparam int PW   = (POOL > 1) ? $clog2(POOL) : 1;

    localparam logic [CNT_BW-1:0] C_END  = CNT_BW'(FMAP_SIZE - 1);
    localparam logic [CNT_BW-1:0] C_LAST = CNT_BW'(LAST);
    localparam logic [CNT_BW-1:0] C_ONE  = CNT_BW'(1);

    logic [CNT_BW-1:0] r_col;
    logic [CNT_BW-1:0] r_row;
    logic [SUM_BW-1:0] r_h;
    logic [SUM_BW-1:0] r_line [POOL];
    logic [SUM_BW-1:0] r_o_y;
    logic              r_o_valid;
    logic              r_o_frame_done;

    logic [SUM_BW-1:0] w_relu;
    logic [SUM_BW-1:0] w_hmax;
    logic [SUM_BW-1:0] w_line_rd;
    logic [SUM_BW-1:0] w_pool;
    logic [PW-1:0]     w_p;
    logic              w_in_win;
    logic              w_pair_done;
    logic              w_line_wr;
    logic              w_emit;
    logic              w_last_win;

    // Odd-sized maps drop the trailing row/column, so only positions up to LAST join a window.
    always_comb begin
        w_relu      = i_y[SUM_BW-1] ? '0 : i_y;
        w_hmax      = (w_relu > r_h) ? w_relu : r_h;
        w_p         = PW'(r_col >> 1);
        w_line_rd   = r_line[w_p];
        w_pool      = (w_line_rd > w_hmax) ? w_line_rd : w_hmax;
        w_in_win    = (r_col <= C_LAST) && (r_row <= C_LAST);
        w_pair_done = i_valid && r_col[0] && w_in_win;
        w_line_wr   = w_pair_done && !r_row[0];
        w_emit      = w_pair_done && r_row[0];
        w_last_win  = (r_row == C_LAST) && (r_col == C_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_h   <= '0;
        end else if (i_valid) begin
            if (!r_col[0]) begin
                r_h <= w_relu;
            end
            if (r_col == C_END) begin
                r_col <= '0;
                r_row <= (r_row == C_END) ? '0 : r_row + C_ONE;
            end else begin
                r_col <= r_col + C_ONE;
            end
        end
    end

    // NOTE: the line buffer has no reset; every entry is written on an even row before an odd row reads it.
    always_ff @(posedge clk) begin
        if (w_line_wr) begin
            r_line[w_p] <= w_hmax;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_y          <= '0;
            r_o_valid      <= 1'b0;
            r_o_frame_done <= 1'b0;
        end else begin
            r_o_valid      <= w_emit;
            r_o_y          <= w_emit ? w_pool : '0;
            r_o_frame_done <= w_emit && w_last_win;
        end
    end

    assign o_y          = r_o_y;
    assign o_valid      = r_o_valid;
    assign o_frame_done = r_o_frame_done;

endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool: a 28x28 and a 5x5 instance checked every cycle against a
// frame-array model, plus literal expectations for ramp, negative, extreme and reset cases.
module tb_relu_maxpool;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b1;
    logic signed [15:0] y28 = '0;
    logic signed [15:0] y5  = '0;
    logic               v28 = 1'b0;
    logic               v5  = 1'b0;
    logic        [15:0] o_y28, o_y5;
    logic               ov28, ov5, fd28, fd5;

    relu_maxpool #(.FMAP_SIZE(28), .SUM_BW(16), .CNT_BW(5)) u_dut28 (
        .clk(clk), .rst(rst), .i_y(y28), .i_valid(v28),
        .o_y(o_y28), .o_valid(ov28), .o_frame_done(fd28)
    );

    relu_maxpool #(.FMAP_SIZE(5), .SUM_BW(16), .CNT_BW(3)) u_dut5 (
        .clk(clk), .rst(rst), .i_y(y5), .i_valid(v5),
        .o_y(o_y5), .o_valid(ov5), .o_frame_done(fd5)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: whole frame stored as a 2-D array; a window's result is the max of its four cells.
    int img [2][28][28];
    int mrow [2];
    int mcol [2];
    int nsz [2] = '{28, 5};
    int exp_v [2];
    int exp_y [2];
    int exp_fd [2];

    task automatic model_step(input int d, input bit r, input bit v, input int y);
        int p, rr, cc, m;
        if (r) begin
            mrow[d] = 0; mcol[d] = 0;
            exp_v[d] = 0; exp_y[d] = 0; exp_fd[d] = 0;
            return;
        end
        exp_v[d] = 0; exp_y[d] = 0; exp_fd[d] = 0;
        if (!v) return;
        rr = mrow[d];
        cc = mcol[d];
        img[d][rr][cc] = (y < 0) ? 0 : y;
        p = nsz[d] / 2;
        if ((rr % 2 == 1) && (cc % 2 == 1) && (rr < 2 * p) && (cc < 2 * p)) begin
            m = img[d][rr-1][cc-1];
            if (img[d][rr-1][cc] > m) m = img[d][rr-1][cc];
            if (img[d][rr][cc-1] > m) m = img[d][rr][cc-1];
            if (img[d][rr][cc] > m) m = img[d][rr][cc];
            exp_v[d]  = 1;
            exp_y[d]  = m;
            exp_fd[d] = (rr == 2 * p - 1 && cc == 2 * p - 1) ? 1 : 0;
        end
        mcol[d]++;
        if (mcol[d] == nsz[d]) begin
            mcol[d] = 0;
            mrow[d]++;
            if (mrow[d] == nsz[d]) mrow[d] = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0, rst, v28, int'(y28));
        model_step(1, rst, v5, int'(y5));
    end

    int cap28[$];
    int cap5[$];
    int fdn28 = 0, fdn5 = 0, fdval28 = -1, fdval5 = -1;

    // Single compare process: outputs sampled on the falling edge against the model.
    initial forever begin
        @(negedge clk);
        check("valid28", ov28, exp_v[0]);
        check("y28", o_y28, exp_y[0]);
        check("done28", fd28, exp_fd[0]);
        check("valid5", ov5, exp_v[1]);
        check("y5", o_y5, exp_y[1]);
        check("done5", fd5, exp_fd[1]);
        if (ov28 === 1'b1) cap28.push_back(int'(o_y28));
        if (ov5 === 1'b1) cap5.push_back(int'(o_y5));
        if (fd28 === 1'b1) begin fdn28++; fdval28 = int'(o_y28); end
        if (fd5 === 1'b1) begin fdn5++; fdval5 = int'(o_y5); end
    end

    task automatic step(input bit a28, input int b28, input bit a5, input int b5);
        @(posedge clk);
        #1;
        v28 = a28; y28 = 16'(b28);
        v5  = a5;  y5  = 16'(b5);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0, 0);
    endtask

    // Reset with a valid sample presented: the sample must be dropped.
    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst = 1'b1; v28 = 1'b1; y28 = 16'sd500; v5 = 1'b1; y5 = 16'sd9;
        end
        @(posedge clk);
        #1;
        rst = 1'b0; v28 = 1'b0; v5 = 1'b0;
    endtask

    task automatic clr();
        cap28.delete(); cap5.delete();
        fdn28 = 0; fdn5 = 0; fdval28 = -1; fdval5 = -1;
    endtask

    function automatic int ramp_exp(input int k);
        return (2 * (k / 14) + 1) * 28 + 2 * (k % 14) + 1;
    endfunction

    task automatic ramp28(input int gap);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                step(1'b1, r * 28 + c, 1'b0, 0);
                if (gap > 0) idle(gap);
            end
    endtask

    task automatic pin_ramp28(input string tag, input int frames);
        check({tag, "_count"}, cap28.size(), 196 * frames);
        for (int k = 0; k < cap28.size() && k < 196 * frames; k++)
            check({tag, "_val"}, cap28[k], ramp_exp(k % 196));
        check({tag, "_done_count"}, fdn28, frames);
        check({tag, "_done_val"}, fdval28, 783);
    endtask

    initial begin
        int f[25];
        int e5[4] = '{6, 8, 16, 18};
        int nz;

        do_reset(3);
        idle(2);
        check("reset_valid28", ov28, 0);
        check("reset_y28", o_y28, 0);

        clr();
        ramp28(0);
        idle(3);
        pin_ramp28("ramp", 1);

        clr();
        for (int i = 0; i < 784; i++) step(1'b1, -1, 1'b0, 0);
        idle(3);
        check("neg_count", cap28.size(), 196);
        nz = 0;
        foreach (cap28[k]) if (cap28[k] != 0) nz++;
        check("neg_nonzero", nz, 0);

        clr();
        ramp28(2);
        idle(3);
        pin_ramp28("gapped", 1);

        for (int i = 0; i < 100; i++) step(1'b1, i, 1'b0, 0);
        idle(1);
        do_reset(2);
        idle(2);
        check("midrst_quiet", ov28, 0);
        clr();
        ramp28(0);
        idle(3);
        pin_ramp28("midrst", 1);

        clr();
        ramp28(0);
        ramp28(0);
        idle(3);
        pin_ramp28("b2b", 2);

        clr();
        for (int fr = 0; fr < 2; fr++)
            for (int i = 0; i < 25; i++) step(1'b0, 0, 1'b1, i);
        idle(3);
        check("odd_count", cap5.size(), 8);
        for (int k = 0; k < cap5.size() && k < 8; k++) check("odd_val", cap5[k], e5[k % 4]);
        check("odd_done_count", fdn5, 2);
        check("odd_done_val", fdval5, 18);

        clr();
        foreach (f[i]) f[i] = int'($urandom_range(0, 200)) - 100;
        f[0] = -32768; f[1] = 7;  f[5] = -5; f[6] = 32767;
        f[2] = -3;     f[3] = -4; f[7] = -5; f[8] = -6;
        for (int i = 0; i < 25; i++) step(1'b0, 0, 1'b1, f[i]);
        idle(3);
        check("extreme_count", cap5.size(), 4);
        if (cap5.size() >= 2) begin
            check("extreme_max", cap5[0], 32767);
            check("extreme_allneg", cap5[1], 0);
        end

        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset(1);
            step($urandom_range(0, 9) < 6, int'($urandom_range(0, 65535)),
                 $urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_maxpool.md
Name: relu_maxpool

Overview:
- Post-convolution stage directly downstream of the convolution engine.
- Consumes the engine's raster-order output stream: signed SUM_BW samples with a valid strobe and arbitrary gaps.
- Applies ReLU, then 2x2 stride-2 max pooling over an FMAP_SIZE x FMAP_SIZE feature map.
- Emits one pooled sample per window and a frame-done pulse.
- Uses a half-row line buffer; no backpressure.

Parameters:
- FMAP_SIZE, 28, width/height of the incoming feature map (DATA_SIZE-KERNEL_SIZE+1); must be >= 2
- SUM_BW, 16, sample width (signed input, non-negative output)
- CNT_BW, 5, row/column counter width; must hold FMAP_SIZE-1

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- i_y  input  SUM_BW  signed conv result; meaningful only when i_valid=1
- i_valid  input  1  sample strobe; one sample per high cycle
- o_y  output  SUM_BW  pooled result; forced to 0 when o_valid=0
- o_valid  output  1  single-cycle strobe per pooled window
- o_frame_done  output  1  high in the same cycle as the last pooled output of a frame

Behaviour:
- Reset (rst=1 at a clock edge):
  - col=0, row=0, horizontal register h=0.
  - o_y=0, o_valid=0, o_frame_done=0.
  - Line buffer contents are don't-care; every entry is written before it is read.
- Reset mid-frame: the partial frame is discarded and produces no output. The next valid sample is treated as (row 0, col 0).
- ReLU: r = (i_y[SUM_BW-1]) ? 0 : i_y. All later comparisons are unsigned on r.
- Position counters advance only on i_valid=1. When i_valid=0, all state holds and o_valid=0.
- col increments 0..FMAP_SIZE-1, then wraps to 0 and increments row.
- row wraps 0..FMAP_SIZE-1. Wrapping from (FMAP_SIZE-1, FMAP_SIZE-1) to (0,0) starts the next frame with no idle cycle required.
- Let p = col>>1. Pooling per valid sample:
  - col even: h <= r.
  - col odd, row even: linebuf[p] <= max(h, r).
  - col odd, row odd: on the next cycle, o_y <= max(linebuf[p], max(h, r)) and o_valid <= 1.
- Odd FMAP_SIZE: samples with col=FMAP_SIZE-1 or row=FMAP_SIZE-1 are consumed (counters advance) but never written or pooled (floor behaviour).
- Line buffer: floor(FMAP_SIZE/2) entries of SUM_BW bits, one write port and one read port. Same-address read and write cannot occur in the same cycle, because writes happen on even rows and reads on odd rows.
- Latency: o_valid is asserted exactly 1 cycle after the i_valid cycle carrying the bottom-right sample of a window.
- Output count: floor(FMAP_SIZE/2)^2 outputs per frame, in raster order of pooled coordinates.
- o_frame_done:
  - One-cycle pulse coincident with the o_valid of pooled window (last, last).
  - Asserted for the window whose bottom-right sample is at row=col=2*floor(FMAP_SIZE/2)-1.
- Simultaneous rst and i_valid: reset wins and the sample is dropped.
- Widths: no arithmetic beyond compare/select; no saturation needed.

Test Plan:
- Ramp frame: FMAP_SIZE=28, continuous i_valid, i_y=row*28+col.
  - 196 outputs; output k=(pr,pc) equals (2pr+1)*28+2pc+1.
  - First o_valid 1 cycle after the 30th sample (value 29).
  - o_frame_done only with the 196th output (value 783).
- All-negative frame: i_y=-1 everywhere -> 196 outputs, all o_y=0; o_y=0 between strobes.
- Gapped ramp: same data as the ramp frame with i_valid high every 3rd cycle -> identical output sequence; each o_valid 1 cycle after its bottom-right sample.
- Extremes in one window: (-32768, 7, -5, 32767) -> o_y=32767. Window (-3, -4, -5, -6) -> o_y=0.
- Reset mid-frame: assert rst after 100 samples, then feed a full ramp frame -> no output during or just after reset; output matches the ramp frame exactly.
- Back-to-back frames plus odd size:
  - Two consecutive ramp frames -> 392 outputs, o_frame_done twice, second frame values identical to the first.
  - FMAP_SIZE=5 instance with ramp i_y=row*5+col -> 4 outputs per frame: 6, 8, 16, 18.
